// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave stream block: FSM states and SPI mode codes.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // SPI mode codes as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchroniser with rise/fall pulse detection.
// Edge pulses are held off until the chain holds only post-reset samples,
// so a line already low when reset releases never looks like a falling edge.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   primed;

  // Shift the input through the synchroniser and keep the previous synchronised sample
  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= {STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
      primed <= '0;
    end else begin
      chain  <= {chain[STAGES-2:0], din};
      prev   <= chain[STAGES-1];
      primed <= {primed[STAGES-1:0], 1'b1};
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = primed[STAGES] & level & ~prev;
  assign fall  = primed[STAGES] & ~level & prev;

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with configurable word width, mode and bit order. Supports
// back-to-back words inside one ssel frame with a one-deep TX holding register.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ssel,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  localparam int         CNT_W       = $clog2(DATA_W);
  localparam logic [1:0] MODE        = {CPOL != 0, CPHA != 0};
  localparam logic       SAMPLE_RISE = (MODE == MODE0) || (MODE == MODE3);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic              reload_pend;

  logic sclk_rise, sclk_fall;
  logic ssel_rise, ssel_fall;
  logic mosi_lvl;
  logic sample_edge, drive_edge;
  logic load_now, ld_empty;
  logic [DATA_W-1:0] ld_word;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .rst(rst), .din(ssel), .level(), .rise(ssel_rise), .fall(ssel_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl), .rise(), .fall()
  );

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign tx_ready = ~hold_full;

  // Edge roles per mode, next RX word, and the word a shift-register load would take
  always_comb begin
    sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    drive_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    if (MSB_FIRST != 0) rx_next = {rx_shift[DATA_W-2:0], mosi_lvl};
    else                rx_next = {mosi_lvl, rx_shift[DATA_W-1:1]};
    // A word offered in the same cycle as an empty-register load bypasses the holding register
    ld_empty = ~hold_full & ~tx_valid;
    if (hold_full)     ld_word = hold_data;
    else if (tx_valid) ld_word = tx_data;
    else               ld_word = '0;
    load_now = ((state == IDLE) && ssel_fall) ||
               ((state == ACTIVE) && !ssel_rise && drive_edge && reload_pend);
  end

  // Frame FSM, TX holding register, shift registers and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      reload_pend <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      if (hold_full) begin
        if (load_now) hold_full <= 1'b0;
      end else if (tx_valid && !load_now) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ssel_fall) begin
            state       <= ACTIVE;
            miso_oe     <= 1'b1;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            rx_shift    <= '0;
            tx_underrun <= ld_empty;
            if (CPHA == 0) begin
              miso     <= first_bit(ld_word);
              tx_shift <= advance(ld_word);
            end else begin
              miso     <= 1'b0;
              tx_shift <= ld_word;
            end
          end
        end
        ACTIVE: begin
          if (ssel_rise) begin
            state       <= IDLE;
            miso_oe     <= 1'b0;
            miso        <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt     <= '0;
                rx_data     <= rx_next;
                rx_valid    <= 1'b1;
                rx_overrun  <= rx_valid;
                reload_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (drive_edge) begin
              if (reload_pend) begin
                miso        <= first_bit(ld_word);
                tx_shift    <= advance(ld_word);
                reload_pend <= 1'b0;
                tx_underrun <= ld_empty;
              end else begin
                miso     <= first_bit(tx_shift);
                tx_shift <= advance(tx_shift);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed testbench for spi_slave_stream: four 8-bit instances (modes 0..3)
// and one 16-bit mode-0 instance, driven by a bit-banged SPI master.
`timescale 1ns/1ps
module tb_spi_slave_stream;

  localparam int T = 6;  // clk cycles per sclk half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  sclk_v, ssel_v, mosi_v, txv_v;
  logic [4:0]  miso_v, oe_v, txr_v, rxv_v, ovr_v, und_v;
  logic [15:0] txd_v [5];
  logic [7:0]  rxd8 [4];
  logic [15:0] rxd16;

  int rxv_cnt [5];
  int und_cnt [5];
  int ovr_cnt [5];
  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] burst_rx [3] = '{16'h1234, 16'hBEEF, 16'h0001};
  logic [15:0] burst_tx [4] = '{16'hA001, 16'h5AC3, 16'hFFFF, 16'h0F0F};

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_stream #(
      .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk_v[g]), .mosi(mosi_v[g]), .ssel(ssel_v[g]),
      .miso(miso_v[g]), .miso_oe(oe_v[g]), .tx_data(txd_v[g][7:0]), .tx_valid(txv_v[g]),
      .tx_ready(txr_v[g]), .rx_data(rxd8[g]), .rx_valid(rxv_v[g]),
      .rx_overrun(ovr_v[g]), .tx_underrun(und_v[g])
    );
  end

  spi_slave_stream #(
    .DATA_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)
  ) u_dut16 (
    .clk(clk), .rst(rst), .sclk(sclk_v[4]), .mosi(mosi_v[4]), .ssel(ssel_v[4]),
    .miso(miso_v[4]), .miso_oe(oe_v[4]), .tx_data(txd_v[4]), .tx_valid(txv_v[4]),
    .tx_ready(txr_v[4]), .rx_data(rxd16), .rx_valid(rxv_v[4]),
    .rx_overrun(ovr_v[4]), .tx_underrun(und_v[4])
  );

  // Pulse counters per instance
  initial for (int i = 0; i < 5; i++) begin rxv_cnt[i] = 0; und_cnt[i] = 0; ovr_cnt[i] = 0; end
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv_v[i]) rxv_cnt[i] <= rxv_cnt[i] + 1;
      if (und_v[i]) und_cnt[i] <= und_cnt[i] + 1;
      if (ovr_v[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cpol(input int m);
    return (m == 2) || (m == 3);
  endfunction

  function automatic logic cpha(input int m);
    return (m == 1) || (m == 3);
  endfunction

  task automatic wait_t(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_frame(input int m);
    ssel_v[m] = 1'b0;
    wait_t(T);
  endtask

  task automatic end_frame(input int m);
    wait_t(T);
    ssel_v[m] = 1'b1;
    wait_t(2 * T);
  endtask

  task automatic push(input int m, input logic [15:0] d);
    int k;
    k = 0;
    while (!txr_v[m] && k < 400) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("push_ready%0d", m), {31'b0, txr_v[m]}, 32'd1);
    txd_v[m] = d;
    txv_v[m] = 1'b1;
    @(negedge clk);
    txv_v[m] = 1'b0;
  endtask

  // Master: shift nbits MSB first, returning the miso bits seen at each sample edge
  task automatic shift_bits(input int m, input int nbits, input logic [31:0] mo,
                            output logic [31:0] mi);
    logic pol, pha;
    pol = cpol(m);
    pha = cpha(m);
    mi  = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        mosi_v[m] = mo[nbits-1-i];
        wait_t(T);
        mi = {mi[30:0], miso_v[m]};
        sclk_v[m] = ~pol;
        wait_t(T);
        sclk_v[m] = pol;
      end else begin
        sclk_v[m] = ~pol;
        mosi_v[m] = mo[nbits-1-i];
        wait_t(T);
        mi = {mi[30:0], miso_v[m]};
        sclk_v[m] = pol;
        wait_t(T);
      end
    end
  endtask

  initial begin
    logic [31:0] mi;
    logic [7:0]  e;
    int c_rx, c_un, c_ov;

    for (int i = 0; i < 5; i++) begin
      sclk_v[i] = cpol(i);
      txd_v[i]  = '0;
    end
    ssel_v = '1;
    mosi_v = '0;
    txv_v  = '0;
    rst    = 1'b1;
    wait_t(4);
    rst = 1'b0;
    wait_t(8);

    // Reset state
    check("reset_miso", {31'b0, miso_v[0]}, 32'd0);
    check("reset_oe", {31'b0, oe_v[0]}, 32'd0);
    check("reset_txready", {31'b0, txr_v[0]}, 32'd1);
    check("reset_rxdata", {24'b0, rxd8[0]}, 32'd0);
    check("reset_rxvalid", {31'b0, rxv_v[0]}, 32'd0);

    // Mode 0 single exchange
    push(0, 16'h00A5);
    c_rx = rxv_cnt[0];
    begin_frame(0);
    check("m0_oe_active", {31'b0, oe_v[0]}, 32'd1);
    shift_bits(0, 8, 32'h3C, mi);
    end_frame(0);
    e = 8'hA5;
    for (int i = 0; i < 8; i++)
      check($sformatf("m0_miso_bit%0d", i), {31'b0, mi[7-i]}, {31'b0, e[7-i]});
    check("m0_rxdata", {24'b0, rxd8[0]}, 32'h3C);
    check("m0_rxvalid_count", rxv_cnt[0] - c_rx, 32'd1);
    check("m0_oe_idle", {31'b0, oe_v[0]}, 32'd0);
    check("m0_miso_idle", {31'b0, miso_v[0]}, 32'd0);

    // All four modes
    for (int m = 0; m < 4; m++) begin
      push(m, 16'h007E);
      c_rx = rxv_cnt[m];
      begin_frame(m);
      shift_bits(m, 8, 32'h81, mi);
      end_frame(m);
      check($sformatf("mode%0d_miso", m), mi, 32'h7E);
      check($sformatf("mode%0d_rxdata", m), {24'b0, rxd8[m]}, 32'h81);
      check($sformatf("mode%0d_rxvalid_count", m), rxv_cnt[m] - c_rx, 32'd1);
    end

    // 16-bit burst of three words with holding register refilled on tx_ready
    push(4, burst_tx[0]);
    c_rx = rxv_cnt[4];
    c_un = und_cnt[4];
    c_ov = ovr_cnt[4];
    fork
      begin
        logic [31:0] bmi;
        begin_frame(4);
        for (int w = 0; w < 3; w++) begin
          shift_bits(4, 16, {16'h0, burst_rx[w]}, bmi);
          check($sformatf("burst_rx%0d", w), {16'h0, rxd16}, {16'h0, burst_rx[w]});
          check($sformatf("burst_miso%0d", w), bmi, {16'h0, burst_tx[w]});
        end
        end_frame(4);
      end
      begin
        for (int w = 1; w < 4; w++) push(4, burst_tx[w]);
      end
    join
    check("burst_rxvalid_count", rxv_cnt[4] - c_rx, 32'd3);
    check("burst_underrun_count", und_cnt[4] - c_un, 32'd0);
    check("burst_overrun_count", ovr_cnt[4] - c_ov, 32'd0);

    // Underrun: empty holding register at frame start
    c_un = und_cnt[0];
    c_rx = rxv_cnt[0];
    begin_frame(0);
    push(0, 16'h005A);
    shift_bits(0, 8, 32'hC3, mi);
    end_frame(0);
    check("underrun_miso", mi, 32'h00);
    check("underrun_count", und_cnt[0] - c_un, 32'd1);
    check("underrun_rxdata", {24'b0, rxd8[0]}, 32'hC3);

    // Abort after 5 bits, then a clean frame
    c_rx = rxv_cnt[0];
    begin_frame(0);
    shift_bits(0, 5, 32'h1F, mi);
    end_frame(0);
    check("abort_rxvalid_count", rxv_cnt[0] - c_rx, 32'd0);
    check("abort_oe", {31'b0, oe_v[0]}, 32'd0);
    check("abort_rxdata_held", {24'b0, rxd8[0]}, 32'hC3);
    push(0, 16'h00C3);
    c_rx = rxv_cnt[0];
    begin_frame(0);
    shift_bits(0, 8, 32'h55, mi);
    end_frame(0);
    check("after_abort_rxdata", {24'b0, rxd8[0]}, 32'h55);
    check("after_abort_miso", mi, 32'hC3);
    check("after_abort_rxvalid_count", rxv_cnt[0] - c_rx, 32'd1);

    // Reset in the middle of a frame
    push(0, 16'h0096);
    begin_frame(0);
    shift_bits(0, 3, 32'h5, mi);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_miso", {31'b0, miso_v[0]}, 32'd0);
    check("midrst_oe", {31'b0, oe_v[0]}, 32'd0);
    check("midrst_rxdata", {24'b0, rxd8[0]}, 32'd0);
    check("midrst_rxvalid", {31'b0, rxv_v[0]}, 32'd0);
    check("midrst_underrun", {31'b0, und_v[0]}, 32'd0);
    check("midrst_txready", {31'b0, txr_v[0]}, 32'd1);
    c_rx = rxv_cnt[0];
    shift_bits(0, 5, 32'h15, mi);
    check("midrst_ignore_oe", {31'b0, oe_v[0]}, 32'd0);
    end_frame(0);
    check("midrst_ignore_rxvalid", rxv_cnt[0] - c_rx, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
Parametrised successor to the team's fixed 8-bit SPI slave. It supports configurable word width, all four SPI modes and bit order. Back-to-back multi-word bursts run within one ssel frame, with a valid/ready TX holding buffer and overrun/underrun flags. It sits between an external SPI master and on-chip register or stream logic, fully in the clk domain, with sclk, mosi and ssel oversampled.

Parameters:
DATA_W, 8, bits per SPI word (2..32)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first on both mosi and miso
SYNC_STAGES, 2, input synchroniser depth (>= 2)

Ports:
clk  in  1  system clock, must run >= 4x sclk frequency
rst  in  1  synchronous active-high reset
sclk  in  1  SPI clock from master, asynchronous
mosi  in  1  master-out data, asynchronous
ssel  in  1  active-low slave select, asynchronous
miso  out  1  slave-out data
miso_oe  out  1  miso output enable, high while the frame is active
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  DATA_W  last complete received word, held until the next word completes
rx_valid  out  1  one-cycle pulse, rx_data updated
rx_overrun  out  1  one-cycle pulse, word completed while the previous rx_valid is still being issued (see Behaviour)
tx_underrun  out  1  one-cycle pulse, word loaded while the holding register was empty

Behaviour:
- Reset (rst high at a clk edge): state IDLE; bit counter 0; miso 0; miso_oe 0; rx_data 0; rx_valid, rx_overrun, tx_underrun 0; holding register empty, so tx_ready 1; synchroniser flops cleared, with ssel synchroniser flops set to 1.
- Sync: sclk, mosi and ssel each pass through SYNC_STAGES flops. Edge detection compares the last two synchronised samples. Leading edge is rising when CPOL=0 and falling when CPOL=1. Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1; drive edge is the other one.
- TX handshake: transfer occurs when tx_valid && tx_ready. tx_ready deasserts the following cycle and reasserts the cycle after the shift register loads from the holding register.
- States: IDLE -> ACTIVE on a synchronised ssel falling edge. ACTIVE -> IDLE on a synchronised ssel rising edge, from any bit position.
- On entering ACTIVE: miso_oe 1; bit counter 0; shift register loaded from the holding register. If the holding register is empty, load all-zeros and pulse tx_underrun.
- CPHA=0: the first bit is on miso in the cycle after entering ACTIVE. On each drive edge, miso takes the next bit.
- CPHA=1: miso takes the first bit on the first leading edge, and the next bit on each later leading edge.
- Sample edge: mosi is shifted into the RX register and the bit counter increments, wrapping at DATA_W.
- Word completion (DATA_W-th sample edge): in the next cycle, rx_data <= the assembled word and rx_valid pulses for one cycle. The shift register reloads from the holding register at the next drive edge, pulsing tx_underrun if the holding register is empty. Bursts of any length continue without gaps.
- rx_overrun: pulses together with rx_valid if the previous rx_valid was issued fewer than 2 cycles earlier. This is only reachable at the minimum clk/sclk ratio; it flags a timing violation.
- Deassert mid-word: the partial word is discarded, with no rx_valid; the bit counter clears; miso_oe drops the next cycle and miso goes to 0. The holding register is kept.
- Simultaneous tx handshake and shift-register load in one cycle: the load takes the old holding contents if present. If the holding register is empty, the new word goes directly into the shift register and no underrun is flagged.
- Reset during ACTIVE: immediate return to IDLE with the reset values above. Any ongoing frame is ignored until the next ssel falling edge.

Decomposition:
- Shared package spi_pkg: state encoding (IDLE, ACTIVE) and mode constants (MODE0..MODE3 as {CPOL,CPHA}).
- One natural sub-module, spi_sync_edge: an SYNC_STAGES-deep synchroniser with rise/fall pulse outputs, instantiated three times for sclk, ssel and mosi (mosi uses the level output only).

Test Plan:
- Mode 0, DATA_W=8: preload tx 0xA5; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1 on successive sample edges; rx_data=0x3C with a single rx_valid pulse.
- All modes: loop over CPOL/CPHA with master sending 0x81 and tx 0x7E -> exchange is bit-exact in all four modes.
- Burst: DATA_W=16, three words 0x1234, 0xBEEF, 0x0001 in one frame, with the tx words refilled on tx_ready -> three rx_valid pulses with matching data; no underrun.
- Underrun: empty holding register at frame start -> miso all 0 for the word; tx_underrun pulses once.
- Abort: ssel deasserted after 5 bits -> no rx_valid; the next full frame receives 0x55 correctly.
- Reset mid-frame: rst asserted at bit 3 -> all outputs at reset values; tx_ready=1.
